// File: rtl/breath_multi.sv
// Multi-channel breathing-LED driver: one triangle-wave phase generator feeding
// CHANNELS PWM outputs, in lockstep or as a phase-shifted chase, with frame-aligned mode/period changes.
`timescale 1ns/1ps
module breath_multi #(
  parameter int CHANNELS    = 8,
  parameter int PWM_BITS    = 8,
  parameter int PERIOD_BITS = 2,
  parameter int BASE_DIV    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [PERIOD_BITS-1:0] io_period,
  input  logic [1:0]             io_mode,
  output logic [CHANNELS-1:0]    io_out
);

  typedef enum logic [1:0] {
    MODE_SYNC  = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_OFF   = 2'd2,
    MODE_ON    = 2'd3
  } mode_t;

  localparam int PH_W    = PWM_BITS + 1;
  localparam int MAX_DIV = BASE_DIV << ((1 << PERIOD_BITS) - 1);
  localparam int PR_W    = ($clog2(MAX_DIV) > 0) ? $clog2(MAX_DIV) : 1;
  // A power-of-two channel count makes the chase offset an exact fraction of one breath.
  localparam logic [PH_W-1:0] OFF_CHASE = PH_W'((1 << PH_W) / CHANNELS);

  logic [PWM_BITS-1:0]    pwm_cnt;
  logic                   fb;
  mode_t                  mode_q;
  logic [PERIOD_BITS-1:0] period_q;
  logic [PR_W-1:0]        presc;
  logic [PR_W-1:0]        presc_lim;
  logic [PH_W-1:0]        phase;
  logic [PH_W-1:0]        off;
  logic [CHANNELS-1:0]    out_d;

  assign fb        = &pwm_cnt;
  assign presc_lim = PR_W'((BASE_DIV << period_q) - 1);

  always_comb begin
    logic [PH_W-1:0]     p;
    logic [PWM_BITS-1:0] lvl;
    off   = (mode_q == MODE_CHASE) ? OFF_CHASE : '0;
    out_d = '0;
    p     = '0;
    lvl   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      p   = phase + PH_W'(i) * off;
      // Upper half of the phase range is the falling slope of the triangle.
      lvl = p[PH_W-1] ? ~p[PWM_BITS-1:0] : p[PWM_BITS-1:0];
      case (mode_q)
        MODE_OFF: out_d[i] = 1'b0;
        MODE_ON:  out_d[i] = 1'b1;
        default:  out_d[i] = (pwm_cnt < lvl);
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt  <= '0;
      mode_q   <= MODE_SYNC;
      period_q <= '0;
      presc    <= '0;
      phase    <= '0;
      io_out   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      io_out  <= out_d;
      if (fb) begin
        mode_q   <= mode_t'(io_mode);
        period_q <= io_period;
        // A period change restarts the prescaler so the new rate begins cleanly.
        if (io_period != period_q) begin
          presc <= '0;
        end else if (presc == presc_lim) begin
          presc <= '0;
          phase <= phase + 1'b1;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_breath_multi.sv
// Bench for breath_multi: frame-level behavioural model checked every cycle,
// plus hand-computed per-frame high counts for sync, chase, period, forced and reset scenarios.
`timescale 1ns/1ps
module tb_breath_multi;

  localparam int NCH = 8;
  localparam int PB  = 4;
  localparam int FR  = 1 << PB;
  localparam int PH  = 2 * FR;

  logic           clock;
  logic           reset;
  logic [1:0]     io_period;
  logic [1:0]     io_mode;
  logic [NCH-1:0] io_out;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int             m_cnt    = 0;
  int             m_phase  = 0;
  int             m_presc  = 0;
  int             m_mode   = 0;
  int             m_period = 0;
  logic [NCH-1:0] exp_out  = '0;

  breath_multi #(
    .CHANNELS(NCH), .PWM_BITS(PB), .PERIOD_BITS(2), .BASE_DIV(1)
  ) dut (
    .clock(clock), .reset(reset), .io_period(io_period), .io_mode(io_mode), .io_out(io_out)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5000 clock = ~clock;
  end

  initial begin
    #(64'd400_000_000);
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // ---------------- model ----------------
  function automatic int tri_level(int p);
    return (p < FR) ? p : (2 * FR - 1 - p);
  endfunction

  function automatic logic [NCH-1:0] model_out(int cnt, int ph, int md);
    logic [NCH-1:0] r;
    int off, p;
    off = (md == 1) ? PH / NCH : 0;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      p = (ph + i * off) % PH;
      if (md == 2) r[i] = 1'b0;
      else if (md == 3) r[i] = 1'b1;
      else r[i] = (cnt < tri_level(p));
    end
    return r;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_cnt <= 0; m_phase <= 0; m_presc <= 0; m_mode <= 0; m_period <= 0;
      exp_out <= '0;
    end else begin
      exp_out <= model_out(m_cnt, m_phase, m_mode);
      m_cnt   <= (m_cnt + 1) % FR;
      if (m_cnt == FR - 1) begin
        m_mode   <= int'(io_mode);
        m_period <= int'(io_period);
        if (int'(io_period) != m_period) m_presc <= 0;
        else if (m_presc == (1 << m_period) - 1) begin
          m_presc <= 0;
          m_phase <= (m_phase + 1) % PH;
        end else m_presc <= m_presc + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    total++;
    if (io_out !== exp_out) begin
      bad++;
      $display("FAIL cycle_cmp t=%0t: got %b want %b", $time, io_out, exp_out);
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Counts high clocks per channel over the next complete frame of output.
  task automatic measure(output int c[NCH]);
    int w;
    w = 0;
    for (int i = 0; i < NCH; i++) c[i] = 0;
    do begin
      @(negedge clock);
      w++;
    end while (m_cnt != 1 && w < 40);
    if (m_cnt != 1) begin
      total++; bad++;
      $display("FAIL frame_align: got timeout want frame start");
      return;
    end
    for (int k = 0; k < FR; k++) begin
      if (k > 0) @(negedge clock);
      for (int ch = 0; ch < NCH; ch++) c[ch] += int'(io_out[ch]);
    end
  endtask

  task automatic do_reset(input int md, input int per);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      io_mode   = 2'($urandom_range(0, 3));
      io_period = 2'($urandom_range(0, 3));
    end
    chk("reset_out", int'(io_out), 0);
    io_mode   = 2'(md);
    io_period = 2'(per);
    reset     = 1'b0;
  endtask

  task automatic check_sync(input string tag, input int frames);
    int c[NCH];
    for (int f = 0; f < frames; f++) begin
      measure(c);
      for (int ch = 0; ch < NCH; ch++)
        chk($sformatf("%s_f%0d_ch%0d", tag, f, ch), c[ch], tri_level(f % PH));
    end
  endtask

  task automatic check_frame(input string tag, input int want[NCH]);
    int c[NCH];
    measure(c);
    for (int ch = 0; ch < NCH; ch++)
      chk($sformatf("%s_ch%0d", tag, ch), c[ch], want[ch]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c[NCH];
    int chase_a[NCH] = '{0, 4, 8, 12, 15, 11, 7, 3};
    int chase_b[NCH] = '{1, 5, 9, 13, 14, 10, 6, 2};
    int zeros[NCH]   = '{default: 0};
    int fulls[NCH]   = '{default: 16};
    int w;

    reset = 1'b1;
    io_mode = 2'd0;
    io_period = 2'd0;

    // Sync breath, one step per frame, then the sequence repeats.
    do_reset(0, 0);
    check_sync("sync", PH + 2);

    // Chase at T=1: first frame still sync/phase 0, then two chase frames at phase 0, then phase 1.
    do_reset(1, 1);
    check_frame("chase_f0", zeros);
    check_frame("chase_f1", chase_a);
    check_frame("chase_f2", chase_a);
    check_frame("chase_f3", chase_b);

    // T=2: period latch skips a step at the first frame boundary, then one step per 4 frames.
    do_reset(0, 2);
    for (int f = 0; f < 10; f++) begin
      measure(c);
      chk($sformatf("per2_f%0d", f), c[0], (f == 0) ? 0 : (f - 1) / 4);
      chk($sformatf("per2_f%0d_ch7", f), c[7], c[0]);
    end
    repeat (5) @(negedge clock);
    io_period = 2'd0;
    for (int f = 11; f < 14; f++) begin
      measure(c);
      chk($sformatf("per0_f%0d", f), c[3], f - 9);
    end

    // Forced on, then forced off, each set mid-frame.
    repeat (5) @(negedge clock);
    io_mode = 2'd3;
    check_frame("force_on", fulls);
    repeat (5) @(negedge clock);
    io_mode = 2'd2;
    check_frame("force_off", zeros);

    // Async reset in the middle of a chase frame.
    io_mode = 2'd1;
    io_period = 2'd0;
    measure(c);
    measure(c);
    w = 0;
    do begin
      @(negedge clock);
      w++;
    end while (m_cnt != 7 && w < 40);
    chk("rst_align", m_cnt, 7);
    #1000;
    reset = 1'b1;
    #1;
    chk("async_rst", int'(io_out), 0);
    do_reset(0, 0);
    check_sync("post_rst", PH);

    // Random mode/period changes at random points, occasional short resets.
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(1, 24)) @(negedge clock);
      io_mode   = 2'($urandom_range(0, 3));
      io_period = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) begin
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
    end
    repeat (2 * FR) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
